// File: rtl/fir_filter_mc.sv
// Time-multiplexed multi-channel FIR: one MAC walks all taps of one channel per sample,
// with shared run-time programmable coefficients, rounding/saturation and req/ack handshakes.
module fir_filter_mc #(
    parameter int Taps        = 16,
    parameter int NumChannels = 2,
    parameter int DataWidth   = 16,
    parameter int CoeffWidth  = 16,
    parameter int CoeffScale  = 12
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic signed [DataWidth-1:0]       data_in_i,
    input  logic [$clog2(NumChannels):0]      data_in_ch_i,
    input  logic                              data_in_req_i,
    output logic                              data_in_ack_o,
    output logic signed [DataWidth-1:0]       data_out_o,
    output logic [$clog2(NumChannels):0]      data_out_ch_o,
    output logic                              data_out_req_o,
    input  logic                              data_out_ack_i,
    input  logic                              coeff_we_i,
    input  logic [$clog2(Taps)-1:0]           coeff_addr_i,
    input  logic signed [CoeffWidth-1:0]      coeff_data_i,
    output logic                              coeff_err_o
);

    localparam int TW     = $clog2(Taps);
    localparam int CIW    = (NumChannels > 1) ? $clog2(NumChannels) : 1;
    localparam int CHW    = $clog2(NumChannels) + 1;
    localparam int ProdW  = DataWidth + CoeffWidth;
    localparam int AccW   = DataWidth + CoeffWidth + $clog2(Taps);
    localparam int Depth  = 2 ** TW;
    localparam int Chans  = 2 ** CIW;
    localparam int RndSh  = (CoeffScale > 0) ? CoeffScale - 1 : 0;

    localparam logic [CHW-1:0] NumChLim = CHW'(NumChannels);
    localparam logic [TW-1:0]  LastTap  = TW'(Taps - 1);
    localparam logic [TW-1:0]  TapsMod  = TW'(Taps);

    localparam logic signed [AccW:0] RndTerm =
        (CoeffScale > 0) ? ({{AccW{1'b0}}, 1'b1} << RndSh) : '0;
    localparam logic signed [AccW:0] MaxVal =
        {{(AccW + 2 - DataWidth){1'b0}}, {(DataWidth - 1){1'b1}}};
    localparam logic signed [AccW:0] MinVal = ~MaxVal;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        PROVIDE
    } state_e;

    state_e state_q, state_d;

    logic signed [CoeffWidth-1:0] coef_q [Depth];
    logic signed [DataWidth-1:0]  hist_q [Chans][Depth];
    logic [TW-1:0]                wptr_q [Chans];
    logic [TW-1:0]                k_q;
    logic [CHW-1:0]               ch_q;
    logic signed [AccW-1:0]       acc_q;

    logic [CIW-1:0]               cur_ch;
    logic [CIW-1:0]               in_ch;
    logic [TW-1:0]                wp_cur;
    logic [TW-1:0]                wp_next;
    logic [TW-1:0]                tap_idx;
    logic signed [ProdW-1:0]      prod;
    logic signed [AccW-1:0]       acc_base;
    logic signed [AccW-1:0]       acc_sum;
    logic                         ch_valid;
    logic                         k_last;

    // Round half up, then clamp to the output range.
    function automatic logic signed [DataWidth-1:0] round_sat(input logic signed [AccW-1:0] a);
        logic signed [AccW:0] r;
        r = {a[AccW-1], a} + RndTerm;
        r = r >>> CoeffScale;
        if (r > MaxVal) begin
            return MaxVal[DataWidth-1:0];
        end else if (r < MinVal) begin
            return MinVal[DataWidth-1:0];
        end
        return r[DataWidth-1:0];
    endfunction

    always_comb begin
        ch_valid = (data_in_ch_i < NumChLim);
        in_ch    = data_in_ch_i[CIW-1:0];
        cur_ch   = ch_q[CIW-1:0];
        wp_cur   = wptr_q[cur_ch];
        k_last   = (k_q == LastTap);
        if (wp_cur >= k_q) begin
            tap_idx = wp_cur - k_q;
        end else begin
            tap_idx = wp_cur + TapsMod - k_q;
        end
        wp_next  = (wp_cur == LastTap) ? '0 : wp_cur + 1'b1;
        prod     = ProdW'(coef_q[k_q]) * ProdW'(hist_q[cur_ch][tap_idx]);
        if (k_q == '0) begin
            acc_base = '0;
        end else begin
            acc_base = acc_q;
        end
        acc_sum  = acc_base + AccW'(prod);
    end

    always_comb begin
        state_d        = state_q;
        data_in_ack_o  = 1'b0;
        data_out_req_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_in_req_i) state_d = LOAD;
            end
            LOAD: begin
                data_in_ack_o = 1'b1;
                state_d       = ch_valid ? RUN : IDLE;
            end
            RUN: begin
                if (k_last) state_d = PROVIDE;
            end
            PROVIDE: begin
                data_out_req_o = 1'b1;
                if (data_out_ack_i) state_d = data_in_req_i ? LOAD : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) coef_q[i] <= '0;
            for (int c = 0; c < Chans; c++) begin
                wptr_q[c] <= '0;
                for (int i = 0; i < Depth; i++) hist_q[c][i] <= '0;
            end
            k_q           <= '0;
            ch_q          <= '0;
            acc_q         <= '0;
            data_out_o    <= '0;
            data_out_ch_o <= '0;
            coeff_err_o   <= 1'b0;
        end else begin
            // Coefficients may only change while no computation is in flight.
            if (coeff_we_i) begin
                if (state_q == IDLE) begin
                    coef_q[coeff_addr_i] <= coeff_data_i;
                end else begin
                    coeff_err_o <= 1'b1;
                end
            end
            case (state_q)
                LOAD: begin
                    if (ch_valid) begin
                        hist_q[in_ch][wptr_q[in_ch]] <= data_in_i;
                        ch_q <= data_in_ch_i;
                        k_q  <= '0;
                    end
                end
                RUN: begin
                    acc_q <= acc_sum;
                    if (k_last) begin
                        // Final tap: publish result and retire the sample slot.
                        data_out_o     <= round_sat(acc_sum);
                        data_out_ch_o  <= ch_q;
                        wptr_q[cur_ch] <= wp_next;
                        k_q            <= '0;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_filter_mc.sv
// Directed bench for fir_filter_mc (4 taps, 2 channels) with a shift-register reference model
// and an every-cycle output monitor.
module tb_fir_filter_mc;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic signed [15:0] data_in_i;
    logic [1:0]         data_in_ch_i;
    logic               data_in_req_i;
    logic               data_in_ack_o;
    logic signed [15:0] data_out_o;
    logic [1:0]         data_out_ch_o;
    logic               data_out_req_o;
    logic               data_out_ack_i;
    logic               coeff_we_i;
    logic [1:0]         coeff_addr_i;
    logic signed [15:0] coeff_data_i;
    logic               coeff_err_o;

    fir_filter_mc #(
        .Taps(4), .NumChannels(2), .DataWidth(16), .CoeffWidth(16), .CoeffScale(12)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .data_in_i(data_in_i), .data_in_ch_i(data_in_ch_i),
        .data_in_req_i(data_in_req_i), .data_in_ack_o(data_in_ack_o),
        .data_out_o(data_out_o), .data_out_ch_o(data_out_ch_o),
        .data_out_req_o(data_out_req_o), .data_out_ack_i(data_out_ack_i),
        .coeff_we_i(coeff_we_i), .coeff_addr_i(coeff_addr_i),
        .coeff_data_i(coeff_data_i), .coeff_err_o(coeff_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        longint d;
        longint ch;
        int     cyc;
    } exp_t;

    int     n_checks = 0;
    int     n_pass   = 0;
    int     cyc      = 0;
    int     hold_cnt = 0;
    bit     checked  = 1'b0;
    bit     expect_load = 1'b0;
    longint held_d;
    longint held_ch;
    longint m_coef [4];
    longint m_hist [2][4];
    exp_t   exp_q [$];
    exp_t   e;
    longint outlog [$];

    always @(posedge clk_i) cyc++;

    task automatic chk(input string name, input longint got, input longint want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, want);
    endtask

    task automatic m_reset();
        for (int k = 0; k < 4; k++) begin
            m_coef[k] = 0;
            m_hist[0][k] = 0;
            m_hist[1][k] = 0;
        end
        exp_q.delete();
    endtask

    // Reference: direct-form convolution over the last four accepted samples of the channel.
    task automatic m_accept(input int ch, input longint d);
        longint acc;
        longint y;
        exp_t   n;
        for (int k = 3; k > 0; k--) m_hist[ch][k] = m_hist[ch][k-1];
        m_hist[ch][0] = d;
        acc = 0;
        for (int k = 0; k < 4; k++) acc += m_coef[k] * m_hist[ch][k];
        y = (acc + 2048) >>> 12;
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        n.d = y;
        n.ch = ch;
        n.cyc = cyc;
        exp_q.push_back(n);
    endtask

    task automatic wait_ack(input int ch, input longint d);
        int n = 0;
        while (!data_in_ack_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (!data_in_ack_o) chk("in_ack_timeout", longint'(data_in_ack_o), 1);
        else if (ch < 2) m_accept(ch, d);
        @(negedge clk_i);
        data_in_req_i = 1'b0;
    endtask

    task automatic send(input int ch, input int d);
        @(negedge clk_i);
        data_in_i     = 16'(d);
        data_in_ch_i  = 2'(ch);
        data_in_req_i = 1'b1;
        wait_ack(ch, longint'(d));
    endtask

    task automatic wr_coef(input int a, input int v, input bit apply);
        @(negedge clk_i);
        coeff_we_i   = 1'b1;
        coeff_addr_i = 2'(a);
        coeff_data_i = 16'(v);
        if (apply) m_coef[a] = longint'(v);
        @(negedge clk_i);
        coeff_we_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || data_out_req_o) && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", longint'(exp_q.size()), 0);
        repeat (2) @(negedge clk_i);
    endtask

    task automatic pin(input string name, input int base, input int idx, input longint want);
        if (outlog.size() > base + idx) chk(name, outlog[base + idx], want);
        else chk({name, "_missing"}, longint'(outlog.size()), longint'(base + idx + 1));
    endtask

    // Output monitor: checks every fresh result against the model and every held cycle for stability.
    always @(negedge clk_i) begin
        #1;
        if (!rst_ni) begin
            data_out_ack_i = 1'b0;
            checked = 1'b0;
            expect_load = 1'b0;
        end else begin
            if (expect_load) chk("load_after_ack", longint'(data_in_ack_o), 1);
            expect_load = 1'b0;
            if (data_out_req_o) begin
                if (!checked) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out", longint'(data_out_req_o), 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", longint'(data_out_o), e.d);
                        chk("out_ch", longint'(data_out_ch_o), e.ch);
                        chk("latency", longint'(cyc - e.cyc), 5);
                        outlog.push_back(longint'(data_out_o));
                    end
                    held_d  = longint'(data_out_o);
                    held_ch = longint'(data_out_ch_o);
                end else begin
                    chk("hold_data", longint'(data_out_o), held_d);
                    chk("hold_ch", longint'(data_out_ch_o), held_ch);
                    chk("hold_in_ack", longint'(data_in_ack_o), 0);
                end
                if (hold_cnt > 0) begin
                    hold_cnt--;
                    data_out_ack_i = 1'b0;
                    checked = 1'b1;
                end else begin
                    data_out_ack_i = 1'b1;
                    checked = 1'b0;
                    expect_load = data_in_req_i;
                end
            end else begin
                data_out_ack_i = 1'b0;
                checked = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int base;
        rst_ni = 1'b0;
        data_in_i = '0;
        data_in_ch_i = '0;
        data_in_req_i = 1'b0;
        data_out_ack_i = 1'b0;
        coeff_we_i = 1'b0;
        coeff_addr_i = '0;
        coeff_data_i = '0;
        m_reset();
        repeat (3) @(negedge clk_i);
        chk("rst_in_ack", longint'(data_in_ack_o), 0);
        chk("rst_out_req", longint'(data_out_req_o), 0);
        chk("rst_out_data", longint'(data_out_o), 0);
        chk("rst_out_ch", longint'(data_out_ch_o), 0);
        chk("rst_err", longint'(coeff_err_o), 0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Decaying impulse response on ch0.
        wr_coef(0, 4096, 1); wr_coef(1, 2048, 1); wr_coef(2, 1024, 1); wr_coef(3, 0, 1);
        base = outlog.size();
        send(0, 100); send(0, 0); send(0, 0); send(0, 0); send(0, 0);
        drain();
        chk("t1_count", longint'(outlog.size() - base), 5);
        pin("t1_y0", base, 0, 100); pin("t1_y1", base, 1, 50); pin("t1_y2", base, 2, 25);
        pin("t1_y3", base, 3, 0); pin("t1_y4", base, 4, 0);

        // Interleaved channels, back-to-back.
        base = outlog.size();
        for (int i = 0; i < 4; i++) begin
            send(0, (i == 0) ? 1000 : 0);
            send(1, 200);
        end
        drain();
        pin("t2_ch0_a", base, 0, 1000); pin("t2_ch0_b", base, 2, 500);
        pin("t2_ch0_c", base, 4, 250);  pin("t2_ch0_d", base, 6, 0);
        pin("t2_ch1_1", base, 3, 300);  pin("t2_ch1_settle", base, 7, 350);

        // Saturation at both rails.
        for (int k = 0; k < 4; k++) wr_coef(k, 4096, 1);
        base = outlog.size();
        for (int i = 0; i < 4; i++) send(0, 32767);
        for (int i = 0; i < 4; i++) send(0, -32768);
        drain();
        pin("t3_pos_sat", base, 3, 32767);
        pin("t3_neg_sat", base, 7, -32768);

        // Rounding with a half-scale tap.
        wr_coef(0, 2048, 1); wr_coef(1, 0, 1); wr_coef(2, 0, 1); wr_coef(3, 0, 1);
        base = outlog.size();
        send(1, 3); send(1, -3); send(1, 1);
        drain();
        pin("t4_r3", base, 0, 2); pin("t4_rm3", base, 1, -1); pin("t4_r1", base, 2, 1);

        // Coefficient write in the same idle cycle as the request.
        base = outlog.size();
        @(negedge clk_i);
        coeff_we_i = 1'b1; coeff_addr_i = 2'd0; coeff_data_i = 16'sd8192;
        data_in_i = 16'sd10; data_in_ch_i = 2'd1; data_in_req_i = 1'b1;
        m_coef[0] = 8192;
        @(negedge clk_i);
        coeff_we_i = 1'b0;
        wait_ack(1, 10);
        drain();
        pin("t4_wr_same_cycle", base, 0, 20);

        // Back-pressure: hold output for 10 cycles with the next request pending.
        base = outlog.size();
        hold_cnt = 10;
        send(0, 40);
        send(0, 0);
        drain();
        pin("t5_held", base, 0, 80);
        chk("t5_err_clear", longint'(coeff_err_o), 0);

        // Coefficient write during RUN is dropped.
        base = outlog.size();
        send(0, 50);
        wr_coef(0, 111, 0);
        send(0, 0);
        drain();
        chk("t6_err_set", longint'(coeff_err_o), 1);
        pin("t6_unchanged", base, 0, 100);

        // Reset in the middle of RUN.
        send(1, 123);
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        m_reset();
        chk("t6_rst_err", longint'(coeff_err_o), 0);
        chk("t6_rst_req", longint'(data_out_req_o), 0);
        chk("t6_rst_data", longint'(data_out_o), 0);
        for (int k = 0; k < 4; k++) wr_coef(k, 4096, 1);
        base = outlog.size();
        send(1, 300);
        drain();
        pin("t6_zero_hist", base, 0, 300);

        // Out-of-range channel: acked, no output, no history change.
        send(3, 77);
        repeat (12) @(negedge clk_i);
        chk("t6_bad_ch_no_out", longint'(outlog.size() - base), 1);
        send(1, 0);
        drain();
        pin("t6_ch_isolated", base, 1, 300);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
